// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: clocked sequencer for a 4:1 mux (MuxMod).
// Steps the mux selects through channels 0..3, holding each for DWELL cycles,
// samples the mux output at the last cycle of each dwell window and reports
// the four samples as a 4-bit result with a one-cycle done pulse.
module mux_scan_ctrl #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mux_o,
  output logic       s1,
  output logic       s,
  output logic       busy,
  output logic       done,
  output logic [3:0] result
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  localparam logic [3:0] RELOAD = 4'(DWELL - 1);

  state_t     state;
  logic [1:0] chan;
  logic [3:0] cnt;
  logic [2:0] shadow;

  // Scan sequencer: select stepping, dwell counting, sampling and completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      chan   <= '0;
      cnt    <= '0;
      shadow <= '0;
      s1     <= 1'b0;
      s      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          {s1, s} <= 2'b00;
          if (start) begin
            state   <= SCAN;
            chan    <= '0;
            cnt     <= RELOAD;
            busy    <= 1'b1;
          end
        end
        SCAN: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else if (chan != 2'd3) begin
            // Samples shift in from the top; after channels 0..2 the
            // channel-0 sample sits in bit 0 and channel-2 in bit 2.
            shadow  <= {mux_o, shadow[2:1]};
            chan    <= chan + 2'd1;
            {s1, s} <= chan + 2'd1;
            cnt     <= RELOAD;
          end else begin
            result  <= {mux_o, shadow};
            done    <= 1'b1;
            busy    <= 1'b0;
            {s1, s} <= 2'b00;
            chan    <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Sequencer placed directly upstream of the 4:1 gate-level mux (MuxMod). Drives the mux selects s1/s so they step through channels d0..d3. Samples the mux output o on each channel and assembles the four samples into a 4-bit result word. Gives the team a clocked front end that scans all four mux inputs per start request and reports completion.

Parameters:
DWELL, 2, cycles each select code is held before mux output is sampled; legal range 1..15.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  synchronous reset, active-high
start  input  1  scan request; sampled only when idle
mux_o  input  1  output o of the MuxMod instance
s1  output  1  mux select MSB, registered
s  output  1  mux select LSB, registered
busy  output  1  high while a scan is in progress
done  output  1  one-cycle pulse when result is updated
result  output  4  bit i = sampled mux_o while channel i was selected

Behaviour:
- All state is updated on rising clk. rst has priority over all other inputs.
- Reset, when rst=1 at an edge:
  - state goes to IDLE; chan=0; cnt=0; shadow=0.
  - outputs: s1=0, s=0, busy=0, done=0, result=4'b0000.
- States are IDLE and SCAN.
  - Internal 2-bit chan.
  - Internal 4-bit cnt.
  - Internal 3-bit shadow holding samples for channels 0..2.
- IDLE:
  - s1/s held at 00; busy=0; done=0 except for the pulse cycle described under SCAN.
  - When start=1 at an edge: state becomes SCAN, chan=0, cnt=DWELL-1, {s1,s}=00, busy=1.
  - When start=0, nothing changes and result holds.
- SCAN, at each edge:
  - {s1,s} = chan at all times.
  - If cnt!=0: cnt decrements.
  - If cnt==0 and chan<3: shadow[chan] is set to mux_o; chan increments; {s1,s} take the new chan; cnt reloads to DWELL-1.
  - If cnt==0 and chan==3: result becomes {mux_o, shadow[2], shadow[1], shadow[0]}; done=1; busy=0; {s1,s}=00; chan=0; state becomes IDLE.
- Timing, with start accepted at edge k:
  - Channel i is selected during cycles k+i*DWELL .. k+(i+1)*DWELL-1.
  - Channel i is sampled at edge k+(i+1)*DWELL.
  - result and done update at edge k+4*DWELL.
  - done is high for exactly one cycle. busy is high for exactly 4*DWELL cycles.
- mux_o is sampled only at the final edge of each dwell window. Mux settling is purely combinational, so DWELL=1 is legal.
- start while busy=1 is ignored, not queued. This includes start at the final sample edge.
- Back-to-back scans: start=1 in the done cycle (IDLE) is accepted. That gives a minimum of one idle cycle between scans.
- result changes only at scan completion or reset. It is stable between scans and during a scan.
- Reset mid-scan aborts the scan immediately:
  - result clears to 0, and no done pulse is generated.
  - A partial shadow is discarded.
- s1 and s change only at edges, so there are no glitches from this block.

Test Plan:
1. DWELL=2; mux d3..d0=1010; rst high 2 cycles, then start pulse at edge k. Required:
   - {s1,s} = 00,01,10,11 for 2 cycles each.
   - busy high for 8 cycles.
   - done pulse at k+8.
   - result=4'b1010.
   - selects return to 00.
2. DWELL=1; mux d3..d0=0111. Required:
   - done at k+4; result=4'b0111.
   - Repeat with d3..d0=1000: result=4'b1000.
3. DWELL=2; during a scan, change d1 from 1 to 0 in the first cycle of channel 1's window. Required: result[1]=0, since only the last window cycle is sampled.
4. Start held high continuously with DWELL=2. Required:
   - Scans complete every 9 cycles.
   - Extra start pulses during busy have no effect.
   - done pulses are exactly 9 cycles apart.
5. Reset mid-scan: assert rst during channel 2 of a scan whose prior result was 4'b1111. Required:
   - Next cycle: result=0, busy=0, {s1,s}=00, no done pulse.
   - A fresh start then completes normally.
6. Exhaustive: DWELL=3; all 16 d3..d0 patterns scanned one after another. Required: each result equals the applied pattern, and done fires at k+12 for every scan.
